sequence_playback: RTL

- Reads a stored colour sequence back out of the 32x4 sequence BRAM and presents it one symbol at a time for display.
- Acts as a read-side user of the BRAM access mux, connected on the user-2 port set; the mux's user select comes from this block's mem_req/mem_grant handshake.
- Each symbol is shown for ON_CYCLES clocks, followed by a blank gap of OFF_CYCLES clocks. A done pulse marks the end of the sequence.

---
 rtl/sequence_playback_if.sv | 20 ++
 rtl/sequence_playback.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/sequence_playback_if.sv
// Read-side BRAM mux port: ownership handshake plus address/data/wren/q.
// The playback block uses the master view; the mux or memory uses the slave view.
interface sequence_playback_if;
    logic       mem_req;
    logic       mem_grant;
    logic [4:0] address;
    logic [3:0] data;
    logic       wren;
    logic [3:0] q;

    modport master (
        output mem_req, address, data, wren,
        input  mem_grant, q
    );

    modport slave (
        input  mem_req, address, data, wren,
        output mem_grant, q
    );
endinterface

// File: rtl/sequence_playback.sv
// Plays the stored colour sequence one symbol at a time with on/off timing.
// Optional PLAYBACK_ABORT_EN adds an abort input that returns to IDLE at once.
module sequence_playback #(
    parameter int ON_CYCLES    = 25000000,
    parameter int OFF_CYCLES   = 12500000,
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  length,
`ifdef PLAYBACK_ABORT_EN
    input  logic        abort,
`endif
    sequence_playback_if.master mem,
    output logic [3:0]  symbol,
    output logic        symbol_valid,
    output logic        busy,
    output logic        done
);

    localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        IDLE, REQ, ADDR, WAIT, SHOW, GAP, FIN
    } state_t;

    state_t          state, state_n;
    logic [4:0]      index, index_n;
    logic [5:0]      len, len_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [1:0]      wcnt, wcnt_n;
    logic [3:0]      sym, sym_n;
    logic            stop;
    logic            last;

`ifdef PLAYBACK_ABORT_EN
    assign stop = abort;
`else
    assign stop = 1'b0;
`endif

    assign last         = ({1'b0, index} == (len - 6'd1));
    assign mem.data     = 4'd0;
    assign mem.wren     = 1'b0;
    assign symbol       = sym;
    assign symbol_valid = (state == SHOW);
    assign busy         = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            index <= '0;
            len   <= '0;
            cnt   <= '0;
            wcnt  <= '0;
            sym   <= '0;
        end else begin
            state <= state_n;
            index <= index_n;
            len   <= len_n;
            cnt   <= cnt_n;
            wcnt  <= wcnt_n;
            sym   <= sym_n;
        end
    end

    always_comb begin
        state_n     = state;
        index_n     = index;
        len_n       = len;
        cnt_n       = cnt;
        wcnt_n      = wcnt;
        sym_n       = sym;
        mem.mem_req = 1'b0;
        mem.address = '0;
        done        = 1'b0;

        unique case (state)
            IDLE: begin
                if (start && !stop) begin
                    len_n   = (length > 6'd32) ? 6'd32 : length;
                    index_n = '0;
                    state_n = (length == 6'd0) ? FIN : REQ;
                end
            end
            REQ: begin
                mem.mem_req = 1'b1;
                if (mem.mem_grant)
                    state_n = ADDR;
            end
            ADDR: begin
                mem.mem_req = 1'b1;
                mem.address = index;
                if (!mem.mem_grant) begin
                    state_n = REQ;
                end else begin
                    wcnt_n  = 2'(READ_LATENCY);
                    state_n = WAIT;
                end
            end
            WAIT: begin
                mem.mem_req = 1'b1;
                mem.address = index;
                // A grant loss on the capture cycle still discards the read.
                if (!mem.mem_grant) begin
                    state_n = REQ;
                end else if (wcnt == 2'd1) begin
                    sym_n   = mem.q;
                    cnt_n   = CW'(ON_CYCLES - 1);
                    state_n = SHOW;
                end else begin
                    wcnt_n = wcnt - 2'd1;
                end
            end
            SHOW: begin
                if (cnt == '0) begin
                    sym_n   = '0;
                    cnt_n   = CW'(OFF_CYCLES - 1);
                    state_n = GAP;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    if (last) begin
                        state_n = FIN;
                    end else begin
                        index_n = index + 5'd1;
                        state_n = REQ;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            FIN: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (stop && state != IDLE) begin
            state_n = IDLE;
            sym_n   = '0;
        end
    end

endmodule
